// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN feature-map datapath blocks.
package cnn_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam int DEF_IMGCOL     = 32;
  localparam int DEF_IMGROW     = 32;
  localparam int DEF_DATA_WIDTH = 8;

  // Counter width for a dimension of n positions; a size-1 dimension still gets one bit.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_collector_if.sv
// Pixel-stream input and whole-frame output of the feature-map collector.
interface fmap_collector_if #(
  parameter int IMGROW     = 32,
  parameter int IMGCOL     = 32,
  parameter int DATA_WIDTH = 8
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_sof;
  logic signed [DATA_WIDTH-1:0] frame_out [IMGROW][IMGCOL];
  logic                         frame_valid;
  logic                         frame_ack;
  logic                         sync_err;
  logic [7:0]                   frame_count;

  // master: the producer/consumer environment around the collector
  modport master (
    output in_valid, in_data, in_sof, frame_ack,
    input  in_ready, frame_out, frame_valid, sync_err, frame_count
  );

  modport slave (
    input  in_valid, in_data, in_sof, frame_ack,
    output in_ready, frame_out, frame_valid, sync_err, frame_count
  );

endinterface

// File: rtl/fmap_bank.sv
// One frame of pixel storage: single write port, whole array visible on the read side.
module fmap_bank
  import cnn_pkg::*;
#(
  parameter int ROWS       = DEF_IMGROW,
  parameter int COLS       = DEF_IMGCOL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROW_W      = pos_width(ROWS),
  parameter int COL_W      = pos_width(COLS)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ROW_W-1:0]             row,
  input  logic [COL_W-1:0]             col,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic signed [DATA_WIDTH-1:0] rd_data [ROWS][COLS]
);

  // Storage is deliberately not reset; contents are only meaningful once the bank is FULL.
  logic signed [DATA_WIDTH-1:0] mem_reg [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[row][col] <= data;
    end
  end

  assign rd_data = mem_reg;

endmodule

// File: rtl/fmap_collector.sv
// Raster pixel stream to ping-pong frame buffer; presents whole frames with valid/ack.
module fmap_collector
  import cnn_pkg::*;
#(
  parameter int IMGCOL     = DEF_IMGCOL,
  parameter int IMGROW     = DEF_IMGROW,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic             clk,
  input logic             rst,
  fmap_collector_if.slave bus
);

  localparam int COL_W = pos_width(IMGCOL);
  localparam int ROW_W = pos_width(IMGROW);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMGCOL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMGROW - 1);

  bank_state_t      state_reg [2];
  bank_state_t      state_next [2];
  logic             wr_sel_reg, wr_sel_next;
  logic             rd_sel_reg, rd_sel_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [7:0]       frame_count_reg, frame_count_next;
  logic             sync_err_reg;

  logic             xfer, resync, frame_done, ack, frame_valid;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;

  logic signed [DATA_WIDTH-1:0] bank0_data [IMGROW][IMGCOL];
  logic signed [DATA_WIDTH-1:0] bank1_data [IMGROW][IMGCOL];

  // Gated by rst so the stream is held off for the whole reset, even before state settles.
  assign bus.in_ready = rst && (state_reg[wr_sel_reg] != FULL);
  assign frame_valid  = (state_reg[rd_sel_reg] == FULL);
  assign bus.frame_valid = frame_valid;
  assign bus.sync_err    = sync_err_reg;
  assign bus.frame_count = frame_count_reg;

  assign xfer   = bus.in_valid && bus.in_ready;
  assign resync = xfer && bus.in_sof && ((row_reg != '0) || (col_reg != '0));
  // A resync pixel restarts the current bank at (0,0); the partial frame is simply overwritten.
  assign wr_row = resync ? '0 : row_reg;
  assign wr_col = resync ? '0 : col_reg;
  assign frame_done = xfer && (wr_row == ROW_LAST) && (wr_col == COL_LAST);
  assign ack        = bus.frame_ack && frame_valid;

  always_comb begin
    row_next         = row_reg;
    col_next         = col_reg;
    wr_sel_next      = wr_sel_reg;
    rd_sel_next      = rd_sel_reg;
    frame_count_next = frame_count_reg;

    if (xfer) begin
      if (wr_col == COL_LAST) begin
        col_next = '0;
        row_next = (wr_row == ROW_LAST) ? '0 : wr_row + 1'b1;
      end else begin
        col_next = wr_col + 1'b1;
        row_next = wr_row;
      end
    end

    // Write and ack never hit the same bank: a FULL read bank blocks in_ready when selects match.
    for (int b = 0; b < 2; b++) begin
      state_next[b] = state_reg[b];
      if (xfer && (wr_sel_reg == 1'(b))) begin
        state_next[b] = frame_done ? FULL : FILLING;
      end
      if (ack && (rd_sel_reg == 1'(b))) begin
        state_next[b] = EMPTY;
      end
    end

    if (frame_done) begin
      wr_sel_next      = ~wr_sel_reg;
      frame_count_next = frame_count_reg + 8'd1;
    end
    if (ack) begin
      rd_sel_next = ~rd_sel_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg[0]    <= EMPTY;
      state_reg[1]    <= EMPTY;
      wr_sel_reg      <= 1'b0;
      rd_sel_reg      <= 1'b0;
      row_reg         <= '0;
      col_reg         <= '0;
      frame_count_reg <= 8'd0;
      sync_err_reg    <= 1'b0;
    end else begin
      state_reg[0]    <= state_next[0];
      state_reg[1]    <= state_next[1];
      wr_sel_reg      <= wr_sel_next;
      rd_sel_reg      <= rd_sel_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      frame_count_reg <= frame_count_next;
      sync_err_reg    <= resync;
    end
  end

  fmap_bank #(
    .ROWS(IMGROW), .COLS(IMGCOL), .DATA_WIDTH(DATA_WIDTH), .ROW_W(ROW_W), .COL_W(COL_W)
  ) u_bank0 (
    .clk(clk), .we(xfer && !wr_sel_reg), .row(wr_row), .col(wr_col),
    .data(bus.in_data), .rd_data(bank0_data)
  );

  fmap_bank #(
    .ROWS(IMGROW), .COLS(IMGCOL), .DATA_WIDTH(DATA_WIDTH), .ROW_W(ROW_W), .COL_W(COL_W)
  ) u_bank1 (
    .clk(clk), .we(xfer && wr_sel_reg), .row(wr_row), .col(wr_col),
    .data(bus.in_data), .rd_data(bank1_data)
  );

  always_comb begin
    for (int r = 0; r < IMGROW; r++) begin
      for (int c = 0; c < IMGCOL; c++) begin
        bus.frame_out[r][c] = rd_sel_reg ? bank1_data[r][c] : bank0_data[r][c];
      end
    end
  end

endmodule

// File: tb/tb_fmap_collector.sv
// Segment table plus frame scoreboard for fmap_collector on a 32x32 frame.
module tb_fmap_collector;

  localparam int R = 32;
  localparam int C = 32;
  localparam int N = R * C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fmap_collector_if #(.IMGROW(R), .IMGCOL(C), .DATA_WIDTH(8)) bus ();

  fmap_collector #(.IMGCOL(C), .IMGROW(R), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef logic [7:0] frame_t [N];

  typedef struct {
    string name;
    int    xfers;
    int    vpct;
    bit    ack_last;
    int    sof_at;
    int    exp_count;
    bit    exp_valid;
    bit    exp_ready;
    int    exp_sync;
  } seg_t;

  frame_t      exp_q [$];
  frame_t      cur;
  frame_t      fml;
  int          pos;
  int          exp_count;
  bit          exp_sync;
  int          n_cmp;
  int          n_bad;
  int          mon_bad;
  int          sync_seen;
  string       mon_msg;
  logic [15:0] pix;
  seg_t        segs [6];

  function automatic logic [7:0] data_of(input logic [15:0] p);
    return p[7:0] + 8'(p[15:10]) * 8'd13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic frame_chk(input string name, input frame_t exp);
    int nb;
    int first;
    nb = 0;
    first = -1;
    for (int i = 0; i < N; i++) begin
      if (8'(bus.frame_out[i / C][i % C]) !== exp[i]) begin
        nb++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (nb != 0) begin
      n_bad++;
      $display("FAIL %s: %0d pixels differ, first [%0d][%0d] got %0d required %0d", name, nb,
               first / C, first % C, 8'(bus.frame_out[first / C][first % C]), exp[first]);
    end else begin
      $display("frame %s: %0d pixels match", name, N);
    end
  endtask

  task automatic mon_chk(input string name);
    n_cmp++;
    if (mon_bad != 0) begin
      n_bad++;
      $display("FAIL %s: %0d cycles off model, required 0; first: %s", name, mon_bad, mon_msg);
    end
    mon_bad = 0;
  endtask

  // One clock: retire ack/transfer seen before the edge into the model, then check outputs.
  task automatic tick();
    bit         xfer, ack, sof, exp_ready, exp_valid;
    logic [7:0] d;
    xfer = bus.in_valid && bus.in_ready;
    ack  = bus.frame_ack && bus.frame_valid;
    sof  = bus.in_sof;
    d    = 8'(bus.in_data);
    if (ack) begin
      if (exp_q.size() == 0) chk("ack_without_frame", 1, 0);
      else begin
        frame_chk("at_ack", exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    exp_sync = 1'b0;
    if (!rst) begin
      exp_q.delete();
      pos = 0;
      exp_count = 0;
    end else if (xfer) begin
      if (sof && pos != 0) begin
        pos = 0;
        exp_sync = 1'b1;
      end
      cur[pos] = d;
      pos++;
      if (pos == N) begin
        exp_q.push_back(cur);
        pos = 0;
        exp_count = (exp_count + 1) % 256;
      end
    end
    exp_ready = rst && (exp_q.size() < 2);
    exp_valid = (exp_q.size() > 0);
    if (bus.in_ready !== exp_ready || bus.frame_valid !== exp_valid ||
        bus.sync_err !== exp_sync || bus.frame_count !== 8'(exp_count)) begin
      if (mon_bad == 0)
        mon_msg = $sformatf("t=%0t ready %b/%b valid %b/%b sync %b/%b count %0d/%0d", $time,
                            bus.in_ready, exp_ready, bus.frame_valid, exp_valid,
                            bus.sync_err, exp_sync, bus.frame_count, exp_count);
      mon_bad++;
    end
    if (bus.sync_err === 1'b1) sync_seen++;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mon_bad = 0; sync_seen = 0; mon_msg = "";
    pos = 0; exp_count = 0; exp_sync = 1'b0; pix = '0;
    bus.in_data = '0;
    idle();
    for (int i = 0; i < N; i++) fml[i] = 8'(i);

    //        name        xfers  vpct ackl sof_at cnt val rdy sync
    segs[0] = '{"frame1",   1024, 100, 0,   -1,   1,  1,  1,  0};
    segs[1] = '{"frame2",   1024, 100, 0,   -1,   2,  1,  0,  0};
    segs[2] = '{"gap_ack",  2048,  60, 1,   -1,   4,  1,  1,  0};
    segs[3] = '{"resync",   1191, 100, 0,  167,   5,  1,  0,  1};
    segs[4] = '{"partial",   300,  80, 0,   -1,   5,  0,  1,  0};
    segs[5] = '{"post_rst", 1024, 100, 0,   -1,   1,  1,  1,  0};

    bus.in_valid = 1'b1;
    repeat (3) tick();
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_frame_valid", bus.frame_valid, 0);
    chk("reset_frame_count", bus.frame_count, 0);
    chk("reset_sync_err", bus.sync_err, 0);
    idle();
    rst = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    mon_chk("mon_reset");

    for (int i = 0; i < 6; i++) begin
      int k;
      int cyc;
      bit acc;
      k = 0;
      cyc = 0;
      sync_seen = 0;
      while (k < segs[i].xfers && cyc < segs[i].xfers * 4 + 200) begin
        bus.in_valid  = ($urandom_range(99) < segs[i].vpct);
        bus.in_data   = data_of(pix);
        bus.in_sof    = (segs[i].sof_at >= 0) ? (k == segs[i].sof_at) : (pos == 0);
        bus.frame_ack = segs[i].ack_last && bus.in_valid && bus.in_ready && (pos == N - 1);
        acc = bus.in_valid && bus.in_ready;
        tick();
        cyc++;
        if (acc) begin
          k++;
          pix++;
        end
      end
      idle();
      $display("segment %s: %0d transfers in %0d cycles, count=%0d valid=%b ready=%b",
               segs[i].name, k, cyc, bus.frame_count, bus.frame_valid, bus.in_ready);
      chk({segs[i].name, "_xfers"}, k, segs[i].xfers);
      chk({segs[i].name, "_count"}, bus.frame_count, segs[i].exp_count);
      chk({segs[i].name, "_valid"}, bus.frame_valid, segs[i].exp_valid);
      chk({segs[i].name, "_ready"}, bus.in_ready, segs[i].exp_ready);
      chk({segs[i].name, "_sync_pulses"}, sync_seen, segs[i].exp_sync);
      mon_chk({"mon_", segs[i].name});

      case (i)
        1: begin
          int blocked;
          blocked = 0;
          bus.in_valid = 1'b1;
          bus.in_data  = data_of(pix);
          repeat (20) begin
            if (bus.in_ready) blocked++;
            tick();
          end
          idle();
          chk("blocked_xfers", blocked, 0);
          frame_chk("frame1_formula", fml);
          pulse_ack();
          chk("ack_ready_back", bus.in_ready, 1);
          chk("ack_valid_stays", bus.frame_valid, 1);
          if (exp_q.size() > 0) frame_chk("frame2_shown", exp_q[0]);
          else chk("frame2_queued", exp_q.size(), 1);
          mon_chk("mon_ack_blocked");
        end
        3: begin
          pulse_ack();
          tick();
          pulse_ack();
          tick();
          pulse_ack();
          tick();
          chk("drain_valid", bus.frame_valid, 0);
          chk("drain_ready", bus.in_ready, 1);
          chk("drain_count", bus.frame_count, 5);
          mon_chk("mon_drain");
        end
        4: begin
          rst = 1'b0;
          bus.in_valid = 1'b1;
          repeat (3) tick();
          chk("rst_mid_in_ready", bus.in_ready, 0);
          chk("rst_mid_valid", bus.frame_valid, 0);
          chk("rst_mid_count", bus.frame_count, 0);
          idle();
          rst = 1'b1;
          #1;
          chk("rst_mid_release_ready", bus.in_ready, 1);
          pix = '0;
          mon_chk("mon_rst_mid");
        end
        5: begin
          frame_chk("post_rst_formula", fml);
          pulse_ack();
          tick();
          chk("post_rst_drained", bus.frame_valid, 0);
          mon_chk("mon_post_rst");
        end
        default: ;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
